tetris_piece_engine: RTL and testbench

//  Owns the active falling tetromino: shape, orientation, four cell coordinates.
//  - Executes SPAWN/LEFT/RIGHT/DOWN/ROTATE commands over a valid/ready handshake.
//  - Collision-checks each candidate position against board bounds and a board-occupancy read port.
//  - Commits or rejects atomically.
//  - Replaces the per-coordinate load-only registers between the tetris control FSM and color_mapper.

---
 rtl/tetris_piece_engine_pkg.sv | 43 ++++
 rtl/tetris_piece_engine_if.sv | 34 +++
 rtl/tetris_piece_engine_candidate.sv | 90 +++++++++
 rtl/tetris_piece_engine.sv | 253 +++++++++++++++++++++++++
 tb/tb_tetris_piece_engine.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_piece_engine_pkg.sv
// Shared types, the orientation-0 shape offset table and the board bounds test
// for the falling-piece engine.
package tetris_piece_engine_pkg;

    typedef enum logic [2:0] {
        CMD_SPAWN  = 3'd0,
        CMD_LEFT   = 3'd1,
        CMD_RIGHT  = 3'd2,
        CMD_DOWN   = 3'd3,
        CMD_ROTATE = 3'd4
    } cmd_e;

    typedef enum logic [2:0] {
        SH_I = 3'd0,
        SH_O = 3'd1,
        SH_T = 3'd2,
        SH_S = 3'd3,
        SH_Z = 3'd4,
        SH_J = 3'd5,
        SH_L = 3'd6
    } shape_e;

    // One 16-bit row per shape: nibble k = {dx[1:0], dy[1:0]} of cell k, cell 1 is the pivot.
    function automatic logic [15:0] shape_row(input shape_e s);
        logic [15:0] row;
        case (s)
            SH_I:    row = 16'hC840;
            SH_O:    row = 16'h5140;
            SH_T:    row = 16'h5840;
            SH_S:    row = 16'h1854;
            SH_Z:    row = 16'h9450;
            SH_J:    row = 16'h9840;
            SH_L:    row = 16'h1840;
            default: row = 16'hC840;
        endcase
        return row;
    endfunction

    function automatic logic cell_in_bounds(input int x, input int y, input int cols, input int rows);
        return (x >= 32'sd0) && (x < cols) && (y >= 32'sd0) && (y < rows);
    endfunction

endpackage

// File: rtl/tetris_piece_engine_if.sv
// Command handshake, board-occupancy query and piece-state bus between the
// game controller and the piece engine.
interface tetris_piece_engine_if #(
    parameter int XW = 5,
    parameter int YW = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd;
    logic [2:0]        spawn_shape;
    logic [XW-1:0]     occ_x;
    logic [YW-1:0]     occ_y;
    logic              occ_hit;
    logic              done;
    logic              accepted;
    logic              landed;
    logic              game_over;
    logic [4*XW-1:0]   cell_x;
    logic [4*YW-1:0]   cell_y;
    logic [2:0]        shape;
    logic [1:0]        orient;

    modport master (
        output cmd_valid, cmd, spawn_shape, occ_hit,
        input  cmd_ready, occ_x, occ_y, done, accepted, landed, game_over,
               cell_x, cell_y, shape, orient
    );

    modport slave (
        input  cmd_valid, cmd, spawn_shape, occ_hit,
        output cmd_ready, occ_x, occ_y, done, accepted, landed, game_over,
               cell_x, cell_y, shape, orient
    );
endinterface

// File: rtl/tetris_piece_engine_candidate.sv
// Combinational next-position generator: current piece + command -> candidate
// cells (signed, one guard bit), shape and orientation.
module tetris_piece_engine_candidate
    import tetris_piece_engine_pkg::*;
#(
    parameter int XW      = 5,
    parameter int YW      = 6,
    parameter int SPAWN_X = 3
) (
    input  logic [4*XW-1:0]     cur_x,
    input  logic [4*YW-1:0]     cur_y,
    input  shape_e              cur_shape,
    input  logic [1:0]          cur_orient,
    input  cmd_e                cmd,
    input  logic [2:0]          spawn_shape,
    output logic [4*(XW+1)-1:0] cand_x,
    output logic [4*(YW+1)-1:0] cand_y,
    output shape_e              cand_shape,
    output logic [1:0]          cand_orient
);
    localparam int CXW = XW + 1;
    localparam int CYW = YW + 1;

    // Per-cell move / rotate / spawn arithmetic, done in int and truncated to the guard width
    always_comb begin
        int px;
        int py;
        int cx;
        int cy;
        int nx;
        int ny;
        logic [15:0] row;
        shape_e sp;
        px  = int'(cur_x[XW +: XW]);
        py  = int'(cur_y[YW +: YW]);
        sp  = (spawn_shape == 3'd7) ? SH_I : shape_e'(spawn_shape);
        row = shape_row(sp);
        cx  = 32'sd0;
        cy  = 32'sd0;
        nx  = 32'sd0;
        ny  = 32'sd0;
        cand_x = {(4*CXW){1'b0}};
        cand_y = {(4*CYW){1'b0}};
        for (int k = 0; k < 4; k++) begin
            cx = int'(cur_x[k*XW +: XW]);
            cy = int'(cur_y[k*YW +: YW]);
            nx = cx;
            ny = cy;
            case (cmd)
                CMD_SPAWN: begin
                    nx = int'(row[k*4+2 +: 2]) + SPAWN_X;
                    ny = int'(row[k*4 +: 2]);
                end
                CMD_LEFT:  nx = cx - 32'sd1;
                CMD_RIGHT: nx = cx + 32'sd1;
                CMD_DOWN:  ny = cy + 32'sd1;
                CMD_ROTATE: begin
                    if (cur_shape != SH_O) begin
                        nx = px - (cy - py);
                        ny = py + (cx - px);
                    end else begin
                        nx = cx;
                        ny = cy;
                    end
                end
                default: begin
                    nx = cx;
                    ny = cy;
                end
            endcase
            cand_x[k*CXW +: CXW] = CXW'(nx);
            cand_y[k*CYW +: CYW] = CYW'(ny);
        end
        case (cmd)
            CMD_SPAWN: begin
                cand_shape  = sp;
                cand_orient = 2'd0;
            end
            CMD_ROTATE: begin
                cand_shape  = cur_shape;
                cand_orient = (cur_shape == SH_O) ? cur_orient : cur_orient + 2'd1;
            end
            default: begin
                cand_shape  = cur_shape;
                cand_orient = cur_orient;
            end
        endcase
    end

endmodule

// File: rtl/tetris_piece_engine.sv
// Active-tetromino owner: accepts one command at a time, probes the four candidate
// cells against bounds and board occupancy, then commits or rejects atomically.
module tetris_piece_engine
    import tetris_piece_engine_pkg::*;
#(
    parameter int COLS    = 10,
    parameter int ROWS    = 20,
    parameter int XW      = 5,
    parameter int YW      = 6,
    parameter int SPAWN_X = 3
) (
    input logic                  clk,
    input logic                  rst,
    tetris_piece_engine_if.slave bus
);
    localparam int CXW = XW + 1;
    localparam int CYW = YW + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CALC    = 3'd1;
    localparam logic [2:0] S_CHK0    = 3'd2;
    localparam logic [2:0] S_CHK1    = 3'd3;
    localparam logic [2:0] S_CHK2    = 3'd4;
    localparam logic [2:0] S_CHK3    = 3'd5;
    localparam logic [2:0] S_RESOLVE = 3'd6;

    logic [2:0]             state_r;
    cmd_e                   cmd_r;
    logic [2:0]             spawn_shape_r;
    logic                   reject_r;
    logic                   fail_r;
    logic [4*CXW-1:0]       cand_x_r;
    logic [4*CXW-1:0]       cand_x_s;
    logic [4*CYW-1:0]       cand_y_r;
    logic [4*CYW-1:0]       cand_y_s;
    shape_e                 cand_shape_r;
    shape_e                 cand_shape_s;
    logic [1:0]             cand_orient_r;
    logic [1:0]             cand_orient_s;
    logic [4*XW-1:0]        cell_x_r;
    logic [4*YW-1:0]        cell_y_r;
    shape_e                 shape_r;
    logic [1:0]             orient_r;
    logic                   piece_valid_r;
    logic                   game_over_r;
    logic                   done_r;
    logic                   accepted_r;
    logic                   landed_r;
    logic                   cmd_ready_r;
    logic [XW-1:0]          occ_x_r;
    logic [XW-1:0]          occ_x_s;
    logic [YW-1:0]          occ_y_r;
    logic [YW-1:0]          occ_y_s;
    logic                   chk_act_s;
    logic [1:0]             chk_idx_s;
    logic                   probe_act_s;
    logic                   probe_fresh_s;
    logic [1:0]             probe_idx_s;
    logic signed [CXW-1:0]  chk_x_s;
    logic signed [CYW-1:0]  chk_y_s;
    logic signed [CXW-1:0]  probe_x_s;
    logic signed [CYW-1:0]  probe_y_s;
    logic                   cell_fail_s;
    logic                   final_fail_s;

    tetris_piece_engine_candidate #(
        .XW      (XW),
        .YW      (YW),
        .SPAWN_X (SPAWN_X)
    ) u_candidate (
        .cur_x       (cell_x_r),
        .cur_y       (cell_y_r),
        .cur_shape   (shape_r),
        .cur_orient  (orient_r),
        .cmd         (cmd_r),
        .spawn_shape (spawn_shape_r),
        .cand_x      (cand_x_s),
        .cand_y      (cand_y_s),
        .cand_shape  (cand_shape_s),
        .cand_orient (cand_orient_s)
    );

    // Which cell is checked this cycle, and which cell is presented on occ_x/occ_y next cycle
    always_comb begin
        chk_act_s     = 1'b0;
        chk_idx_s     = 2'd0;
        probe_act_s   = 1'b0;
        probe_fresh_s = 1'b0;
        probe_idx_s   = 2'd0;
        case (state_r)
            S_CALC: begin
                probe_act_s   = 1'b1;
                probe_fresh_s = 1'b1;
            end
            S_CHK0: begin
                chk_act_s   = 1'b1;
                probe_act_s = 1'b1;
                probe_idx_s = 2'd1;
            end
            S_CHK1: begin
                chk_act_s   = 1'b1;
                chk_idx_s   = 2'd1;
                probe_act_s = 1'b1;
                probe_idx_s = 2'd2;
            end
            S_CHK2: begin
                chk_act_s   = 1'b1;
                chk_idx_s   = 2'd2;
                probe_act_s = 1'b1;
                probe_idx_s = 2'd3;
            end
            S_CHK3: begin
                chk_act_s = 1'b1;
                chk_idx_s = 2'd3;
            end
            default: begin
                chk_act_s   = 1'b0;
                probe_act_s = 1'b0;
            end
        endcase
    end

    // Cell failure test and next occupancy query; out-of-bounds cells query (0,0)
    always_comb begin
        chk_x_s = cand_x_r[int'(chk_idx_s)*CXW +: CXW];
        chk_y_s = cand_y_r[int'(chk_idx_s)*CYW +: CYW];
        if (probe_fresh_s) begin
            probe_x_s = cand_x_s[0 +: CXW];
            probe_y_s = cand_y_s[0 +: CYW];
        end else begin
            probe_x_s = cand_x_r[int'(probe_idx_s)*CXW +: CXW];
            probe_y_s = cand_y_r[int'(probe_idx_s)*CYW +: CYW];
        end
        cell_fail_s = chk_act_s &&
                      (!cell_in_bounds(int'(chk_x_s), int'(chk_y_s), COLS, ROWS) || bus.occ_hit);
        if (probe_act_s && cell_in_bounds(int'(probe_x_s), int'(probe_y_s), COLS, ROWS)) begin
            occ_x_s = probe_x_s[XW-1:0];
            occ_y_s = probe_y_s[YW-1:0];
        end else begin
            occ_x_s = {XW{1'b0}};
            occ_y_s = {YW{1'b0}};
        end
        final_fail_s = fail_r | cell_fail_s | reject_r;
    end

    // Command FSM, candidate capture, commit and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= S_IDLE;
            cmd_r         <= CMD_SPAWN;
            spawn_shape_r <= 3'd0;
            reject_r      <= 1'b0;
            fail_r        <= 1'b0;
            cand_x_r      <= {(4*CXW){1'b0}};
            cand_y_r      <= {(4*CYW){1'b0}};
            cand_shape_r  <= SH_I;
            cand_orient_r <= 2'd0;
            cell_x_r      <= {(4*XW){1'b0}};
            cell_y_r      <= {(4*YW){1'b0}};
            shape_r       <= SH_I;
            orient_r      <= 2'd0;
            piece_valid_r <= 1'b0;
            game_over_r   <= 1'b0;
            done_r        <= 1'b0;
            accepted_r    <= 1'b0;
            landed_r      <= 1'b0;
            cmd_ready_r   <= 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_r) begin
                        cmd_r         <= cmd_e'(bus.cmd);
                        spawn_shape_r <= bus.spawn_shape;
                        reject_r      <= (bus.cmd != 3'd0) &&
                                         (!piece_valid_r || game_over_r || (bus.cmd > 3'd4));
                        fail_r        <= 1'b0;
                        cmd_ready_r   <= 1'b0;
                        state_r       <= S_CALC;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_CALC: begin
                    cand_x_r      <= cand_x_s;
                    cand_y_r      <= cand_y_s;
                    cand_shape_r  <= cand_shape_s;
                    cand_orient_r <= cand_orient_s;
                    state_r       <= S_CHK0;
                end
                S_CHK0, S_CHK1, S_CHK2: begin
                    fail_r  <= fail_r | cell_fail_s;
                    state_r <= state_r + 3'd1;
                end
                S_CHK3: begin
                    done_r     <= 1'b1;
                    accepted_r <= !final_fail_s;
                    landed_r   <= final_fail_s && (cmd_r == CMD_DOWN);
                    // A blocked spawn still places the piece so the final board can be shown
                    if (!final_fail_s || (cmd_r == CMD_SPAWN)) begin
                        for (int k = 0; k < 4; k++) begin
                            cell_x_r[k*XW +: XW] <= cand_x_r[k*CXW +: XW];
                            cell_y_r[k*YW +: YW] <= cand_y_r[k*CYW +: YW];
                        end
                        shape_r  <= cand_shape_r;
                        orient_r <= cand_orient_r;
                    end
                    if (cmd_r == CMD_SPAWN) begin
                        piece_valid_r <= 1'b1;
                        if (final_fail_s) begin
                            game_over_r <= 1'b1;
                        end
                    end
                    state_r <= S_RESOLVE;
                end
                S_RESOLVE: begin
                    done_r      <= 1'b0;
                    accepted_r  <= 1'b0;
                    landed_r    <= 1'b0;
                    cmd_ready_r <= 1'b1;
                    state_r     <= S_IDLE;
                end
                default: begin
                    cmd_ready_r <= 1'b1;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    // Registered occupancy query address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_x_r <= {XW{1'b0}};
            occ_y_r <= {YW{1'b0}};
        end else begin
            occ_x_r <= occ_x_s;
            occ_y_r <= occ_y_s;
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.occ_x     = occ_x_r;
    assign bus.occ_y     = occ_y_r;
    assign bus.done      = done_r;
    assign bus.accepted  = accepted_r;
    assign bus.landed    = landed_r;
    assign bus.game_over = game_over_r;
    assign bus.cell_x    = cell_x_r;
    assign bus.cell_y    = cell_y_r;
    assign bus.shape     = shape_r;
    assign bus.orient    = orient_r;

endmodule

// File: tb/tb_tetris_piece_engine.sv
// Directed bench for tetris_piece_engine: spawn, wall and floor collisions,
// rotation, game over, back-to-back commands and reset during a command.
module tb_tetris_piece_engine;

    localparam logic [2:0] C_SPAWN  = 3'd0;
    localparam logic [2:0] C_LEFT   = 3'd1;
    localparam logic [2:0] C_RIGHT  = 3'd2;
    localparam logic [2:0] C_DOWN   = 3'd3;
    localparam logic [2:0] C_ROTATE = 3'd4;

    logic clk = 1'b0;
    logic rst;
    int   occ_mode;
    int   n_cmp;
    int   n_bad;
    int   lat;
    logic acc;
    logic lnd;

    always #5 clk = ~clk;

    tetris_piece_engine_if #(.XW(5), .YW(6)) ifc ();

    tetris_piece_engine #(
        .COLS(10), .ROWS(20), .XW(5), .YW(6), .SPAWN_X(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Board model: 0 empty, 1 row 3 occupied, 2 everything occupied
    assign ifc.occ_hit = (occ_mode == 2) ? 1'b1 :
                         ((occ_mode == 1) ? (ifc.occ_y == 6'd3) : 1'b0);

    function automatic logic [19:0] xs(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    function automatic logic [23:0] ys(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    task automatic run_cmd(input logic [2:0] c, input logic [2:0] s,
                           output int l, output logic a, output logic d);
        int n;
        n = 0;
        while ((ifc.cmd_ready !== 1'b1) && (n < 30)) begin
            @(negedge clk);
            n++;
        end
        ifc.cmd         = c;
        ifc.spawn_shape = s;
        ifc.cmd_valid   = 1'b1;
        @(posedge clk);
        #1 ifc.cmd_valid = 1'b0;
        l = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ifc.done === 1'b1) begin
                l = i;
                break;
            end
        end
        a = ifc.accepted;
        d = ifc.landed;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd = 3'd0;
        ifc.spawn_shape = 3'd0;
        occ_mode = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ifc.cmd_ready, ifc.done, ifc.accepted, ifc.landed, ifc.game_over} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 10000",
                     {ifc.cmd_ready, ifc.done, ifc.accepted, ifc.landed, ifc.game_over});
        end
        n_cmp++;
        if ({ifc.cell_x, ifc.cell_y, ifc.shape, ifc.orient, ifc.occ_x, ifc.occ_y} !== 60'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h want 0",
                     {ifc.cell_x, ifc.cell_y, ifc.shape, ifc.orient, ifc.occ_x, ifc.occ_y});
        end
        rst = 1'b0;
        @(negedge clk);
        run_cmd(C_RIGHT, 3'd0, lat, acc, lnd);
        n_cmp++;
        if ({lat == 6, acc, lnd} !== 3'b100) begin
            n_bad++;
            $display("FAIL no_piece_right: got lat=%0d acc=%b lnd=%b want lat=6 acc=0 lnd=0", lat, acc, lnd);
        end
        n_cmp++;
        if (ifc.cell_x !== 20'd0) begin
            n_bad++;
            $display("FAIL no_piece_cells: got %h want 0", ifc.cell_x);
        end
    endtask

    task automatic test_spawn();
        run_cmd(C_SPAWN, 3'd2, lat, acc, lnd);
        n_cmp++;
        if (lat !== 6) begin
            n_bad++;
            $display("FAIL spawn_latency: got %0d want 6", lat);
        end
        n_cmp++;
        if ({acc, lnd, ifc.game_over} !== 3'b100) begin
            n_bad++;
            $display("FAIL spawn_flags: got %b want 100", {acc, lnd, ifc.game_over});
        end
        n_cmp++;
        if ({ifc.cell_x, ifc.cell_y} !== {xs(3, 4, 5, 4), ys(0, 0, 0, 1)}) begin
            n_bad++;
            $display("FAIL spawn_cells: got %h/%h want %h/%h", ifc.cell_x, ifc.cell_y, xs(3, 4, 5, 4), ys(0, 0, 0, 1));
        end
        n_cmp++;
        if ({ifc.shape, ifc.orient} !== 5'b010_00) begin
            n_bad++;
            $display("FAIL spawn_shape: got %b want 01000", {ifc.shape, ifc.orient});
        end
    endtask

    task automatic test_left_wall();
        for (int i = 0; i < 3; i++) begin
            run_cmd(C_LEFT, 3'd0, lat, acc, lnd);
            n_cmp++;
            if ({lat == 6, acc} !== 2'b11) begin
                n_bad++;
                $display("FAIL left_step%0d: got lat=%0d acc=%b want lat=6 acc=1", i, lat, acc);
            end
        end
        n_cmp++;
        if ({ifc.cell_x, ifc.cell_y} !== {xs(0, 1, 2, 1), ys(0, 0, 0, 1)}) begin
            n_bad++;
            $display("FAIL left_cells: got %h/%h want %h/%h", ifc.cell_x, ifc.cell_y, xs(0, 1, 2, 1), ys(0, 0, 0, 1));
        end
        run_cmd(C_LEFT, 3'd0, lat, acc, lnd);
        n_cmp++;
        if ({lat == 6, acc, lnd} !== 3'b100) begin
            n_bad++;
            $display("FAIL left_wall: got lat=%0d acc=%b lnd=%b want lat=6 acc=0 lnd=0", lat, acc, lnd);
        end
        n_cmp++;
        if (ifc.cell_x !== xs(0, 1, 2, 1)) begin
            n_bad++;
            $display("FAIL left_wall_cells: got %h want %h", ifc.cell_x, xs(0, 1, 2, 1));
        end
    endtask

    task automatic test_rotate();
        run_cmd(C_SPAWN, 3'd2, lat, acc, lnd);
        run_cmd(C_DOWN, 3'd0, lat, acc, lnd);
        run_cmd(C_DOWN, 3'd0, lat, acc, lnd);
        n_cmp++;
        if ({ifc.cell_x, ifc.cell_y} !== {xs(3, 4, 5, 4), ys(2, 2, 2, 3)}) begin
            n_bad++;
            $display("FAIL down2_cells: got %h/%h want %h/%h", ifc.cell_x, ifc.cell_y, xs(3, 4, 5, 4), ys(2, 2, 2, 3));
        end
        run_cmd(C_ROTATE, 3'd0, lat, acc, lnd);
        n_cmp++;
        if ({lat == 6, acc} !== 2'b11) begin
            n_bad++;
            $display("FAIL rotate_flags: got lat=%0d acc=%b want lat=6 acc=1", lat, acc);
        end
        n_cmp++;
        if ({ifc.cell_x, ifc.cell_y, ifc.orient} !== {xs(4, 4, 4, 3), ys(1, 2, 3, 2), 2'd1}) begin
            n_bad++;
            $display("FAIL rotate_cells: got %h/%h/%0d want %h/%h/1", ifc.cell_x, ifc.cell_y, ifc.orient, xs(4, 4, 4, 3), ys(1, 2, 3, 2));
        end
    endtask

    task automatic test_landing();
        occ_mode = 1;
        run_cmd(C_DOWN, 3'd0, lat, acc, lnd);
        occ_mode = 0;
        n_cmp++;
        if ({lat == 6, acc, lnd} !== 3'b101) begin
            n_bad++;
            $display("FAIL land_flags: got lat=%0d acc=%b lnd=%b want lat=6 acc=0 lnd=1", lat, acc, lnd);
        end
        n_cmp++;
        if ({ifc.cell_x, ifc.cell_y} !== {xs(4, 4, 4, 3), ys(1, 2, 3, 2)}) begin
            n_bad++;
            $display("FAIL land_cells: got %h/%h want %h/%h", ifc.cell_x, ifc.cell_y, xs(4, 4, 4, 3), ys(1, 2, 3, 2));
        end
    endtask

    task automatic test_shapes();
        run_cmd(C_SPAWN, 3'd1, lat, acc, lnd);
        run_cmd(C_ROTATE, 3'd0, lat, acc, lnd);
        n_cmp++;
        if ({acc, ifc.orient, ifc.shape} !== {1'b1, 2'd0, 3'd1}) begin
            n_bad++;
            $display("FAIL o_rotate_flags: got acc=%b orient=%0d shape=%0d want 1/0/1", acc, ifc.orient, ifc.shape);
        end
        n_cmp++;
        if ({ifc.cell_x, ifc.cell_y} !== {xs(3, 4, 3, 4), ys(0, 0, 1, 1)}) begin
            n_bad++;
            $display("FAIL o_rotate_cells: got %h/%h want %h/%h", ifc.cell_x, ifc.cell_y, xs(3, 4, 3, 4), ys(0, 0, 1, 1));
        end
        run_cmd(C_SPAWN, 3'd7, lat, acc, lnd);
        n_cmp++;
        if ({acc, ifc.shape, ifc.cell_x, ifc.cell_y} !== {1'b1, 3'd0, xs(3, 4, 5, 6), ys(0, 0, 0, 0)}) begin
            n_bad++;
            $display("FAIL shape7_as_i: got acc=%b shape=%0d %h/%h want 1/0 %h/0", acc, ifc.shape, ifc.cell_x, ifc.cell_y, xs(3, 4, 5, 6));
        end
    endtask

    task automatic test_right_wall();
        for (int i = 0; i < 3; i++) begin
            run_cmd(C_RIGHT, 3'd0, lat, acc, lnd);
            n_cmp++;
            if (acc !== 1'b1) begin
                n_bad++;
                $display("FAIL right_step%0d: got acc=%b want 1", i, acc);
            end
        end
        run_cmd(C_RIGHT, 3'd0, lat, acc, lnd);
        n_cmp++;
        if ({acc, lnd, ifc.cell_x} !== {2'b00, xs(6, 7, 8, 9)}) begin
            n_bad++;
            $display("FAIL right_wall: got acc=%b lnd=%b x=%h want 0/0 %h", acc, lnd, ifc.cell_x, xs(6, 7, 8, 9));
        end
    endtask

    task automatic test_back_to_back();
        int n_done;
        int first_at;
        int second_at;
        n_done = 0;
        first_at = -1;
        second_at = -1;
        while (ifc.cmd_ready !== 1'b1) @(negedge clk);
        ifc.cmd = C_DOWN;
        ifc.cmd_valid = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (ifc.done === 1'b1) begin
                n_done++;
                if (n_done == 1) first_at = i;
                if (n_done == 2) second_at = i;
            end
        end
        ifc.cmd_valid = 1'b0;
        n_cmp++;
        if ({n_done, first_at, second_at} !== {32'sd2, 32'sd6, 32'sd13}) begin
            n_bad++;
            $display("FAIL b2b_timing: got n=%0d at %0d,%0d want 2 at 6,13", n_done, first_at, second_at);
        end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ifc.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        n_cmp++;
        if ({lat > 0, ifc.cell_y} !== {1'b1, ys(3, 3, 3, 3)}) begin
            n_bad++;
            $display("FAIL b2b_cells: got lat=%0d y=%h want third done, y=%h", lat, ifc.cell_y, ys(3, 3, 3, 3));
        end
    endtask

    task automatic test_game_over();
        occ_mode = 2;
        run_cmd(C_SPAWN, 3'd0, lat, acc, lnd);
        n_cmp++;
        if ({lat == 6, acc, lnd, ifc.game_over} !== 4'b1001) begin
            n_bad++;
            $display("FAIL go_spawn: got lat=%0d acc=%b lnd=%b go=%b want 6/0/0/1", lat, acc, lnd, ifc.game_over);
        end
        n_cmp++;
        if ({ifc.cell_x, ifc.cell_y, ifc.shape} !== {xs(3, 4, 5, 6), ys(0, 0, 0, 0), 3'd0}) begin
            n_bad++;
            $display("FAIL go_spawn_cells: got %h/%h want %h/0", ifc.cell_x, ifc.cell_y, xs(3, 4, 5, 6));
        end
        run_cmd(C_LEFT, 3'd0, lat, acc, lnd);
        n_cmp++;
        if ({acc, lnd, ifc.game_over, ifc.cell_x} !== {3'b001, xs(3, 4, 5, 6)}) begin
            n_bad++;
            $display("FAIL go_left: got acc=%b lnd=%b go=%b x=%h want 0/0/1 %h", acc, lnd, ifc.game_over, ifc.cell_x, xs(3, 4, 5, 6));
        end
        occ_mode = 0;
        run_cmd(C_SPAWN, 3'd2, lat, acc, lnd);
        run_cmd(C_DOWN, 3'd0, lat, acc, lnd);
        n_cmp++;
        if ({acc, ifc.game_over, ifc.cell_y} !== {2'b01, ys(0, 0, 0, 1)}) begin
            n_bad++;
            $display("FAIL go_sticky: got acc=%b go=%b y=%h want 0/1 %h", acc, ifc.game_over, ifc.cell_y, ys(0, 0, 0, 1));
        end
    endtask

    task automatic test_reset_midcmd();
        int n_done;
        while (ifc.cmd_ready !== 1'b1) @(negedge clk);
        ifc.cmd = C_LEFT;
        ifc.cmd_valid = 1'b1;
        @(posedge clk);
        #1 ifc.cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({ifc.occ_x, ifc.occ_y} !== {5'd4, 6'd0}) begin
            n_bad++;
            $display("FAIL chk2_probe: got (%0d,%0d) want (4,0)", ifc.occ_x, ifc.occ_y);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ifc.cmd_ready, ifc.done, ifc.accepted, ifc.landed, ifc.game_over} !== 5'b10000) begin
            n_bad++;
            $display("FAIL midrst_flags: got %b want 10000",
                     {ifc.cmd_ready, ifc.done, ifc.accepted, ifc.landed, ifc.game_over});
        end
        n_cmp++;
        if ({ifc.cell_x, ifc.cell_y, ifc.shape, ifc.orient, ifc.occ_x, ifc.occ_y} !== 60'd0) begin
            n_bad++;
            $display("FAIL midrst_state: got %h want 0",
                     {ifc.cell_x, ifc.cell_y, ifc.shape, ifc.orient, ifc.occ_x, ifc.occ_y});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ifc.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_ready: got %b want 1", ifc.cmd_ready);
        end
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifc.done === 1'b1) n_done++;
        end
        n_cmp++;
        if ({n_done, ifc.cell_x} !== {32'sd0, 20'd0}) begin
            n_bad++;
            $display("FAIL midrst_no_done: got dones=%0d x=%h want 0/0", n_done, ifc.cell_x);
        end
        run_cmd(C_RIGHT, 3'd0, lat, acc, lnd);
        n_cmp++;
        if ({lat == 6, acc} !== 2'b10) begin
            n_bad++;
            $display("FAIL midrst_piece_cleared: got lat=%0d acc=%b want 6/0", lat, acc);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_spawn();
        test_left_wall();
        test_rotate();
        test_landing();
        test_shapes();
        test_right_wall();
        test_back_to_back();
        test_game_over();
        test_reset_midcmd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
